// File: rtl/refresh_scheduler.sv
// Periodic DRAM refresh scheduler: accrues refresh debt per interval,
// retires it on RefAck rising edges, and flags lost refresh ticks.
//
// Ports:
//   CLK       in   system clock, all logic on posedge
//   RST       in   synchronous active-high reset
//   En        in   refresh timer enable
//   RefAck    in   refresh acknowledge from RAM controller (level, multi-cycle)
//   ClrOvf    in   clears the sticky Overflow flag
//   RefReq    out  refresh pending (Debt != 0)
//   RefUrgent out  refresh overdue (Debt >= URGENT_LEVEL)
//   Overflow  out  sticky: a tick was lost at saturated debt
//   Debt      out  current outstanding refresh count
module refresh_scheduler #(
    parameter int REF_INTERVAL = 250,
    parameter int DEBT_WIDTH   = 4,
    parameter int INIT_DEBT    = 8,
    parameter int URGENT_LEVEL = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  En,
    input  logic                  RefAck,
    input  logic                  ClrOvf,
    output logic                  RefReq,
    output logic                  RefUrgent,
    output logic                  Overflow,
    output logic [DEBT_WIDTH-1:0] Debt
);

    localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REF_INTERVAL - 1);
    localparam logic [DEBT_WIDTH-1:0] DEBT_MAX = '1;
    localparam logic [DEBT_WIDTH-1:0] DEBT_INI = DEBT_WIDTH'(INIT_DEBT);
    localparam logic [DEBT_WIDTH-1:0] URG_LVL  = DEBT_WIDTH'(URGENT_LEVEL);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEBT_WIDTH-1:0] debt_q, debt_d;
    logic                  ovf_q, ovf_d;
    logic                  ack_prev_q;
    logic                  tick;
    logic                  ack_rise;
    logic                  ovf_set;

    assign tick     = En && (cnt_q == CNT_LAST);
    assign ack_rise = RefAck && !ack_prev_q;

    // Timer: free-runs while enabled, held at zero otherwise.
    always_comb begin
        cnt_d = '0;
        if (En && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A coincident tick and ack cancel out, so only the lone cases
    // move the debt; saturation in either direction is a hold.
    always_comb begin
        debt_d  = debt_q;
        ovf_set = 1'b0;
        if (tick && !ack_rise) begin
            if (debt_q == DEBT_MAX) begin
                ovf_set = 1'b1;
            end else begin
                debt_d = debt_q + 1'b1;
            end
        end else if (ack_rise && !tick) begin
            if (debt_q != '0) begin
                debt_d = debt_q - 1'b1;
            end
        end
    end

    // Set has priority over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    // ack_prev_q resets high so an ack already in flight is never counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            debt_q     <= DEBT_INI;
            ovf_q      <= 1'b0;
            ack_prev_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            debt_q     <= debt_d;
            ovf_q      <= ovf_d;
            ack_prev_q <= RefAck;
        end
    end

    // Pure decodes of the debt register: no input-to-output paths.
    assign Debt      = debt_q;
    assign Overflow  = ovf_q;
    assign RefReq    = (debt_q != '0);
    assign RefUrgent = (debt_q >= URG_LVL);

endmodule

// File: tb/tb_refresh_scheduler.sv
// Testbench for refresh_scheduler: directed vectors, a per-cycle
// integer reference model and hand-computed literal checkpoints.
module tb_refresh_scheduler;

    localparam int RI   = 250;
    localparam int DW   = 4;
    localparam int INI  = 8;
    localparam int URG  = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          En = 1'b0;
    logic          RefAck = 1'b0;
    logic          ClrOvf = 1'b0;
    logic          RefReq;
    logic          RefUrgent;
    logic          Overflow;
    logic [DW-1:0] Debt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // reference model state
    int m_debt = 0;
    int m_ovf = 0;
    int m_prev = 1;
    int m_run = 0;

    refresh_scheduler #(
        .REF_INTERVAL(RI),
        .DEBT_WIDTH  (DW),
        .INIT_DEBT   (INI),
        .URGENT_LEVEL(URG)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .En       (En),
        .RefAck   (RefAck),
        .ClrOvf   (ClrOvf),
        .RefReq   (RefReq),
        .RefUrgent(RefUrgent),
        .Overflow (Overflow),
        .Debt     (Debt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: debt moves by (ticks - ack rises) per cycle, clamped to
    // [0, DMAX]; an upward clamp is a lost tick.
    always @(posedge CLK) begin
        int tick;
        int rise;
        int nxt;
        int setovf;
        if (RST) begin
            m_debt = INI;
            m_ovf  = 0;
            m_prev = 1;
            m_run  = 0;
        end else begin
            tick = 0;
            if (En) begin
                tick  = ((m_run % RI) == RI - 1) ? 1 : 0;
                m_run = m_run + 1;
            end else begin
                m_run = 0;
            end
            rise   = (RefAck && m_prev == 0) ? 1 : 0;
            nxt    = m_debt + tick - rise;
            setovf = 0;
            if (nxt > DMAX) begin
                nxt    = DMAX;
                setovf = 1;
            end
            if (nxt < 0) nxt = 0;
            m_debt = nxt;
            if (setovf == 1) m_ovf = 1;
            else if (ClrOvf) m_ovf = 0;
            m_prev = RefAck ? 1 : 0;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("model_debt", int'(Debt), m_debt);
            chk("model_req", int'(RefReq), (m_debt != 0) ? 1 : 0);
            chk("model_urg", int'(RefUrgent), (m_debt >= URG) ? 1 : 0);
            chk("model_ovf", int'(Overflow), m_ovf);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        RefAck = 1'b1;
        cyc(hi);
        RefAck = 1'b0;
        cyc(lo);
    endtask

    initial begin
        // 1: reset and power-up burst drain
        cyc(1);
        RST = 1'b0;
        chk_on = 1'b1;
        chk("rst_debt", int'(Debt), 8);
        chk("rst_req", int'(RefReq), 1);
        chk("rst_urg", int'(RefUrgent), 1);
        chk("rst_ovf", int'(Overflow), 0);
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) pulse(20, 2);
            else pulse(4, 2);
            chk("drain_debt", int'(Debt), 7 - i);
        end
        chk("drain_req", int'(RefReq), 0);
        chk("drain_urg", int'(RefUrgent), 0);

        // 2: first tick on the 250th enabled cycle
        En = 1'b1;
        cyc(249);
        chk("pre_tick_debt", int'(Debt), 0);
        cyc(1);
        chk("tick_debt", int'(Debt), 1);
        chk("tick_req", int'(RefReq), 1);
        chk("tick_urg", int'(RefUrgent), 0);

        // 3: second interval makes it urgent, one ack relieves it
        cyc(250);
        chk("two_debt", int'(Debt), 2);
        chk("two_urg", int'(RefUrgent), 1);
        RefAck = 1'b1;
        cyc(1);
        chk("ack_debt", int'(Debt), 1);
        chk("ack_urg", int'(RefUrgent), 0);
        chk("ack_req", int'(RefReq), 1);
        cyc(3);
        RefAck = 1'b0;

        // 4: tick coincident with ack rise, at debt 1 then at debt 0
        En = 1'b0;
        cyc(2);
        En = 1'b1;
        cyc(249);
        RefAck = 1'b1;
        cyc(1);
        chk("coin1_debt", int'(Debt), 1);
        cyc(3);
        RefAck = 1'b0;
        En = 1'b0;
        cyc(2);
        pulse(4, 2);
        chk("to_zero_debt", int'(Debt), 0);
        En = 1'b1;
        cyc(249);
        RefAck = 1'b1;
        cyc(1);
        chk("coin0_debt", int'(Debt), 0);
        cyc(3);
        RefAck = 1'b0;
        pulse(4, 2);
        chk("spurious_debt", int'(Debt), 0);

        // 5: saturation and overflow
        En = 1'b0;
        cyc(1);
        En = 1'b1;
        cyc(RI * 15);
        chk("sat_debt", int'(Debt), 15);
        chk("sat_ovf", int'(Overflow), 0);
        cyc(RI);
        chk("ovf_debt", int'(Debt), 15);
        chk("ovf_set", int'(Overflow), 1);
        ClrOvf = 1'b1;
        cyc(1);
        ClrOvf = 1'b0;
        chk("ovf_clr", int'(Overflow), 0);
        cyc(RI - 2);
        ClrOvf = 1'b1;
        cyc(1);
        ClrOvf = 1'b0;
        chk("ovf_set_wins", int'(Overflow), 1);
        chk("ovf_hold_debt", int'(Debt), 15);

        // 6: reset during an in-flight ack
        En = 1'b0;
        for (int i = 0; i < 12; i++) pulse(4, 2);
        chk("pre_rst_debt", int'(Debt), 3);
        RefAck = 1'b1;
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(3);
        chk("inflight_debt", int'(Debt), INI);
        chk("inflight_ovf", int'(Overflow), 0);
        RefAck = 1'b0;
        cyc(1);
        RefAck = 1'b1;
        cyc(1);
        chk("fresh_rise_debt", int'(Debt), INI - 1);
        RefAck = 1'b0;
        cyc(300);
        chk("no_tick_debt", int'(Debt), INI - 1);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
